scan_chain_ctrl: RTL and testbench
==================================

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, number of cells in the driven scan chain (legal 2..64).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-004 SHALL have port START  input  1  one-cycle request to run one load/capture/unload test.
REQ-005 SHALL have port ABORT  input  1  synchronous cancel of a running test.
REQ-006 SHALL have port PATTERN  input  CHAIN_LEN  stimulus; bit i is destined for chain cell i (cell 0 at SI end, cell CHAIN_LEN-1 at SO end).
REQ-007 SHALL have port SO  input  1  scan-out, i.e. the Q of chain cell CHAIN_LEN-1.
REQ-008 SHALL have port SE  output  1  scan enable to every chain cell.
REQ-009 SHALL have port SI  output  1  scan data into chain cell 0.
REQ-010 SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-012 SHALL have port RESP  output  CHAIN_LEN  unloaded response; bit i is the captured value of cell i.

Function
REQ-013 SHALL implement FSM IDLE -> SHIFT -> CAPTURE -> UNLOAD -> FINISH -> IDLE.
REQ-014 SHALL, in IDLE only, accept START: latch PATTERN (and the compare inputs when enabled), clear the bit counter, and enter SHIFT; START outside IDLE is ignored.
REQ-015 SHALL drive SE and SI from flops, glitch-free, as a Moore function of state and shift register.
REQ-016 SHALL, in SHIFT, hold SE=1 for exactly CHAIN_LEN cycles, presenting PATTERN[CHAIN_LEN-1] first and PATTERN[0] last on SI, one bit per cycle.
REQ-017 SHALL, in CAPTURE, hold SE=0, SI=0 for exactly one cycle.
REQ-018 SHALL, in UNLOAD, hold SE=1, SI=0 for exactly CHAIN_LEN cycles, sampling SO at the closing edge of each cycle; the first sample goes to RESP[CHAIN_LEN-1] and the last to RESP[0].
REQ-019 SHALL, in FINISH, assert DONE for exactly one cycle, with SE=0; RESP (and PASS) are valid from that cycle and hold until the next accepted START.
REQ-020 SHALL therefore assert DONE in the (2*CHAIN_LEN+2)th cycle after the edge that accepted START.
REQ-021 SHALL size the bit counter as $clog2(CHAIN_LEN) bits and terminate on count==CHAIN_LEN-1 with no wrap past it.
REQ-022 SHALL, on ABORT in any non-IDLE state, enter IDLE at the next edge with SE=0, SI=0, no DONE, RESP unchanged; ABORT takes priority over START in the same cycle; ABORT in IDLE has no effect.

Reset
REQ-023 SHALL, while RST_N is low (including mid-test), force state IDLE, SE=0, SI=0, BUSY=0, DONE=0, RESP=0, PASS=0, counter=0.
REQ-024 SHALL resume accepting START on the first edge after RST_N deasserts.

Configuration
REQ-025 SHALL, with macro SCAN_CMP_EN defined, add inputs EXPECT and MASK (CHAIN_LEN each, latched on START) and output PASS, registered in FINISH as ((RESP ^ EXPECT) & MASK) == 0.
REQ-026 SHALL, without SCAN_CMP_EN, omit EXPECT, MASK and PASS, with no compare logic; all other behaviour is unchanged.

Structure
REQ-027 SHALL take the FSM state enum and the CHAIN_LEN bounds constants from shared package scan_pkg.
REQ-028 SHALL place the masked compare in sub-module scan_resp_cmp, instantiated only under SCAN_CMP_EN.

Verification
REQ-029 SHALL cover: CHAIN_LEN=8 chain of scan cells with D=~Q, PATTERN=8'hA5, EXPECT=8'h5A, MASK=8'hFF -> RESP=8'h5A, PASS=1, DONE 18 cycles after START.
REQ-030 SHALL cover: same stimulus with EXPECT=8'h5B -> PASS=0; then MASK=8'hFE -> PASS=1.
REQ-031 SHALL cover: SE trace per test -> exactly 8 high, 1 low, 8 high, then low; SI order matches PATTERN bits 7..0.
REQ-032 SHALL cover: START pulsed in SHIFT -> ignored, single DONE only; ABORT in UNLOAD -> IDLE next cycle, SE=0, no DONE, RESP keeps prior value.
REQ-033 SHALL cover: RST_N low for 2 cycles mid-CAPTURE -> all outputs 0 immediately; a new START after release completes normally.
REQ-034 SHALL cover: build without SCAN_CMP_EN -> RESP=8'h5A for the REQ-029 stimulus; EXPECT, MASK and PASS absent.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan chain controller.
package scan_pkg;

    localparam int unsigned CHAIN_LEN_MIN = 2;
    localparam int unsigned CHAIN_LEN_MAX = 64;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCapture,
        StUnload,
        StFinish
    } scan_state_e;

endpackage

// File: rtl/scan_resp_cmp.sv
// Masked compare of an unloaded scan response against an expected word.
module scan_resp_cmp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] resp,
    input  logic [WIDTH-1:0] exp_word,
    input  logic [WIDTH-1:0] mask,
    output logic             match
);

    assign match = (((resp ^ exp_word) & mask) == '0);

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load/capture/unload controller for a single scan chain.
// Define SCAN_CMP_EN to add EXPECT/MASK inputs and the registered PASS result.
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CHAIN_LEN-1:0] PATTERN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP
`ifdef SCAN_CMP_EN
    ,
    input  logic [CHAIN_LEN-1:0] EXPECT,
    input  logic [CHAIN_LEN-1:0] MASK,
    output logic                 PASS
`endif
);

    localparam int unsigned CntW = $clog2(CHAIN_LEN);
    localparam logic [CntW-1:0] CntLast = CntW'(CHAIN_LEN - 1);

    if (CHAIN_LEN < CHAIN_LEN_MIN || CHAIN_LEN > CHAIN_LEN_MAX) begin : g_bad_len
        $error("CHAIN_LEN out of range");
    end

    scan_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Pattern bits still to be shifted; the MSB already sits in si_q.
    logic [CHAIN_LEN-2:0] sr_q, sr_d;
    logic [CHAIN_LEN-2:0] cap_q, cap_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic [CHAIN_LEN-1:0] unload_word;
    logic                 se_q, se_d, si_q, si_d, done_q, done_d;
    logic                 accept, finishing;

    assign unload_word = {cap_q, SO};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        cap_d     = cap_q;
        resp_d    = resp_q;
        si_d      = 1'b0;
        accept    = 1'b0;
        finishing = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    accept  = 1'b1;
                    state_d = StShift;
                    cnt_d   = '0;
                    sr_d    = PATTERN[CHAIN_LEN-2:0];
                    si_d    = PATTERN[CHAIN_LEN-1];
                end
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    state_d = StCapture;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    si_d  = sr_q[CHAIN_LEN-2];
                    sr_d  = sr_q << 1;
                end
            end
            StCapture: state_d = StUnload;
            StUnload: begin
                cap_d = unload_word[CHAIN_LEN-2:0];
                if (cnt_q == CntLast) begin
                    state_d   = StFinish;
                    cnt_d     = '0;
                    resp_d    = unload_word;
                    finishing = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Abort discards any partial unload so RESP keeps the last full result.
        if (ABORT && state_q != StIdle) begin
            state_d   = StIdle;
            cnt_d     = '0;
            resp_d    = resp_q;
            si_d      = 1'b0;
            finishing = 1'b0;
        end
        se_d   = (state_d == StShift) || (state_d == StUnload);
        done_d = (state_d == StFinish);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            cap_q   <= '0;
            resp_q  <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            cap_q   <= cap_d;
            resp_q  <= resp_d;
            se_q    <= se_d;
            si_q    <= si_d;
            done_q  <= done_d;
        end
    end

    assign SE   = se_q;
    assign SI   = si_q;
    assign DONE = done_q;
    assign RESP = resp_q;
    assign BUSY = (state_q != StIdle);

`ifdef SCAN_CMP_EN
    logic [CHAIN_LEN-1:0] exp_q, mask_q;
    logic                 pass_q, cmp_match;

    scan_resp_cmp #(
        .WIDTH(CHAIN_LEN)
    ) u_cmp (
        .resp    (unload_word),
        .exp_word(exp_q),
        .mask    (mask_q),
        .match   (cmp_match)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_q  <= '0;
            mask_q <= '0;
            pass_q <= 1'b0;
        end else begin
            if (accept) begin
                exp_q  <= EXPECT;
                mask_q <= MASK;
            end
            if (finishing) begin
                pass_q <= cmp_match;
            end
        end
    end

    assign PASS = pass_q;
`else
    logic unused_accept;
    assign unused_accept = accept ^ finishing;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench: drives scan_chain_ctrl against a D=~Q scan chain model.
module tb_scan_chain_ctrl;

    localparam int unsigned N = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic         ABORT = 1'b0;
    logic [N-1:0] PATTERN = '0;
    logic         SO;
    logic         SE, SI, BUSY, DONE;
    logic [N-1:0] RESP;
`ifdef SCAN_CMP_EN
    logic [N-1:0] EXPECT = '0;
    logic [N-1:0] MASK = '0;
    logic         PASS;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] model_resp = '0;
    logic         model_pass = 1'b0;

    // Scan cells: shift when SE, otherwise capture the inverse of their own Q.
    logic [N-1:0] chain = '0;
    always @(posedge CLK) begin
        if (SE) chain <= {chain[N-2:0], SI};
        else    chain <= ~chain;
    end
    assign SO = chain[N-1];

    always #5 CLK = ~CLK;

    scan_chain_ctrl #(
        .CHAIN_LEN(N)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .ABORT  (ABORT),
        .PATTERN(PATTERN),
        .SO     (SO),
        .SE     (SE),
        .SI     (SI),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESP   (RESP)
`ifdef SCAN_CMP_EN
        ,
        .EXPECT (EXPECT),
        .MASK   (MASK),
        .PASS   (PASS)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One test over a 24-cycle window; cycle c is the c-th cycle after the accepting edge.
    task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] exp_w,
                            input logic [N-1:0] msk, input int restart_at, input int abort_at);
        logic [31:0] se_tr, si_tr, busy_tr, exp_se, exp_si, exp_busy;
        int          done_cnt, done_cyc;
        bit          live;
        se_tr = '0; si_tr = '0; busy_tr = '0;
        exp_se = '0; exp_si = '0; exp_busy = '0;
        done_cnt = 0; done_cyc = 0;
        PATTERN = pat;
`ifdef SCAN_CMP_EN
        EXPECT = exp_w;
        MASK   = msk;
`endif
        START = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge CLK);
            se_tr[c]   = SE;
            si_tr[c]   = SI;
            busy_tr[c] = BUSY;
            if (DONE) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            START   = (c == restart_at);
            ABORT   = (c == abort_at);
            PATTERN = ~pat;
`ifdef SCAN_CMP_EN
            EXPECT = ~exp_w;
            MASK   = ~msk;
`endif
        end
        for (int c = 1; c <= 24; c++) begin
            live = (abort_at == 0) || (c <= abort_at);
            exp_se[c]   = live && ((c <= N) || (c >= N + 2 && c <= 2 * N + 1));
            exp_busy[c] = live && (c <= 2 * N + 2);
            if (c <= N) exp_si[c] = live & pat[N-c];
        end
        if (abort_at == 0) begin
            model_resp = ~pat;
            model_pass = (((model_resp ^ exp_w) & msk) == '0);
        end
        check("se_trace", se_tr, exp_se);
        check("si_trace", si_tr, exp_si);
        check("busy_trace", busy_tr, exp_busy);
        check("done_count", done_cnt, (abort_at == 0) ? 1 : 0);
        check("done_cycle", done_cyc, (abort_at == 0) ? 2 * N + 2 : 0);
        check("resp", 32'(RESP), 32'(model_resp));
`ifdef SCAN_CMP_EN
        check("pass", 32'(PASS), 32'(model_pass));
`endif
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_outputs", {SE, SI, BUSY, DONE, RESP}, '0);
`ifdef SCAN_CMP_EN
        check("reset_pass", 32'(PASS), 32'd0);
`endif
        RST_N = 1'b1;

        run_test(8'hA5, 8'h5A, 8'hFF, 0, 0);
        run_test(8'hA5, 8'h5B, 8'hFF, 0, 0);
        run_test(8'hA5, 8'h5B, 8'hFE, 0, 0);
        run_test(N'($urandom), N'($urandom), N'($urandom), 3, 0);
        run_test(N'($urandom), N'($urandom), N'($urandom), 12, 0);
        run_test(N'($urandom), 8'h00, 8'h00, 0, 12);
        run_test(N'($urandom), N'($urandom), N'($urandom), 0, 4);

        // Reset during CAPTURE, then a fresh test right after release.
        PATTERN = N'($urandom);
        START = 1'b1;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        check("capture_se_low", {SE, BUSY}, 2'b01);
        RST_N = 1'b0;
        #1;
        check("async_reset_outputs", {SE, SI, BUSY, DONE, RESP}, '0);
        repeat (2) @(negedge CLK);
        check("held_reset_outputs", {SE, SI, BUSY, DONE, RESP}, '0);
`ifdef SCAN_CMP_EN
        check("held_reset_pass", 32'(PASS), 32'd0);
`endif
        model_resp = '0;
        model_pass = 1'b0;
        RST_N = 1'b1;
        run_test(N'($urandom), N'($urandom), N'($urandom), 0, 0);

        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] p;
            p = N'($urandom);
            run_test(p, ~p ^ N'($urandom_range(0, 3)), N'($urandom), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
